// File: rtl/next_pc_unit.sv
// Next-PC selection for the fetch stage: BOOT -> RUN -> HALTED FSM with stall, jump and branch redirects.
// Optional return-address capture is compiled in when NEXT_PC_LINK_EN is defined.
module next_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        branch_en,
    input  logic [31:0] branch_off,
    input  logic        link_en,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] link_addr
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic        mis_q;
    logic        mis_nxt;
    logic [31:0] redir_raw;
    logic [31:0] seq_pc;

    // Jump wins over branch; additions wrap modulo 2^32.
    assign redir_raw = jump_en ? jump_target : (pc_q + branch_off);
    assign seq_pc    = pc_q + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            mis_q <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        mis_nxt   = mis_q;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (stall) begin
                    pc_nxt = pc_q;
                end else if (jump_en || branch_en) begin
                    // Misaligned targets are forced to a word boundary and flagged.
                    pc_nxt = {redir_raw[31:2], 2'b00};
                    if (redir_raw[1:0] != 2'b00) begin
                        mis_nxt = 1'b1;
                    end
                end else begin
                    pc_nxt = seq_pc;
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = BOOT;
        endcase
    end

    assign pc         = pc_q;
    assign pc_valid   = (state == RUN);
    assign halted     = (state == HALTED);
    assign misaligned = mis_q;

`ifdef NEXT_PC_LINK_EN
    logic [31:0] link_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_q <= 32'h0;
        end else if (state == RUN && !halt && !stall && jump_en && link_en) begin
            link_q <= seq_pc;
        end
    end

    assign link_addr = link_q;
`else
    logic unused_link;

    assign unused_link = &{1'b0, link_en};
    assign link_addr   = 32'h0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: reset, sequential fetch, branch/wrap, priority,
// misaligned redirects, halt, reset during a redirect and link capture.
module tb_next_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_en;
    logic [31:0] branch_off;
    logic        link_en;
    logic [31:0] pc;
    logic        pc_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] link_addr;

    int n_checks = 0;
    int n_pass   = 0;

    next_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .halt       (halt),
        .jump_en    (jump_en),
        .jump_target(jump_target),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .link_en    (link_en),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .halted     (halted),
        .misaligned (misaligned),
        .link_addr  (link_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall = 0; halt = 0; jump_en = 0; jump_target = 0;
        branch_en = 0; branch_off = 0; link_en = 0;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release on a falling edge so the next rising edge leaves BOOT.
    task automatic do_reset();
        clear_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // Run out of BOOT and jump to an aligned address.
    task automatic goto_pc(input logic [31:0] addr);
        tick();
        jump_en = 1; jump_target = addr;
        tick();
        jump_en = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        #2;
        rst = 1;
        #1;
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (pc_valid !== 1'b0) $display("FAIL reset_pc_valid got %b want 0", pc_valid); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
        n_checks++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned got %b want 0", misaligned); else n_pass++;
        n_checks++; if (link_addr !== 32'h0) $display("FAIL reset_link_addr got %h want 0", link_addr); else n_pass++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        #1;
        n_checks++; if (pc_valid !== 1'b0) $display("FAIL boot_pc_valid got %b want 0", pc_valid); else n_pass++;
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (pc_valid !== 1'b1) $display("FAIL seq_pc_valid[%0d] got %b want 1", i, pc_valid); else n_pass++;
            n_checks++; if (pc !== exp_pc) $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc); else n_pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_branch_wrap();
        do_reset();
        goto_pc(32'h100);
        n_checks++; if (pc !== 32'h100) $display("FAIL jump_0x100 got %h want 100", pc); else n_pass++;
        branch_en = 1; branch_off = 32'hFFFF_FFF0;
        tick();
        branch_en = 0;
        n_checks++; if (pc !== 32'hF0) $display("FAIL branch_back got %h want f0", pc); else n_pass++;
        jump_en = 1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump_en = 0;
        n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL jump_top got %h want fffffffc", pc); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL wrap got %h want 0", pc); else n_pass++;
        n_checks++; if (misaligned !== 1'b0) $display("FAIL aligned_no_flag got %b want 0", misaligned); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        goto_pc(32'h40);
        stall = 1; jump_en = 1; jump_target = 32'h200;
        tick();
        n_checks++; if (pc !== 32'h40) $display("FAIL stall_over_jump got %h want 40", pc); else n_pass++;
        stall = 0;
        tick();
        jump_en = 0;
        n_checks++; if (pc !== 32'h200) $display("FAIL jump_after_stall got %h want 200", pc); else n_pass++;
        jump_en = 1; jump_target = 32'h300; branch_en = 1; branch_off = 32'h10;
        tick();
        jump_en = 0; branch_en = 0;
        n_checks++; if (pc !== 32'h300) $display("FAIL jump_over_branch got %h want 300", pc); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h304) $display("FAIL step_after_jump got %h want 304", pc); else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        tick();
        jump_en = 1; jump_target = 32'h203;
        tick();
        jump_en = 0;
        n_checks++; if (pc !== 32'h200) $display("FAIL mis_jump_pc got %h want 200", pc); else n_pass++;
        n_checks++; if (misaligned !== 1'b1) $display("FAIL mis_jump_flag got %b want 1", misaligned); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (misaligned !== 1'b1) $display("FAIL mis_sticky[%0d] got %b want 1", i, misaligned); else n_pass++;
        end
        rst = 1;
        #1;
        n_checks++; if (misaligned !== 1'b0) $display("FAIL mis_cleared got %b want 0", misaligned); else n_pass++;
        do_reset();
        tick();
        branch_en = 1; branch_off = 32'h6;
        tick();
        branch_en = 0;
        n_checks++; if (pc !== 32'h4) $display("FAIL mis_branch_pc got %h want 4", pc); else n_pass++;
        n_checks++; if (misaligned !== 1'b1) $display("FAIL mis_branch_flag got %b want 1", misaligned); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        goto_pc(32'h80);
        halt = 1;
        tick();
        halt = 0;
        n_checks++; if (pc !== 32'h80) $display("FAIL halt_pc got %h want 80", pc); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else n_pass++;
        n_checks++; if (pc_valid !== 1'b0) $display("FAIL halt_pc_valid got %b want 0", pc_valid); else n_pass++;
        jump_en = 1; jump_target = 32'h501; branch_en = 1; branch_off = 32'h40;
        tick();
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h80) $display("FAIL halt_ignores_jump got %h want 80", pc); else n_pass++;
        n_checks++; if (misaligned !== 1'b0) $display("FAIL halt_no_mis got %b want 0", misaligned); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_stays got %b want 1", halted); else n_pass++;
        rst = 1;
        #1;
        n_checks++; if (pc !== 32'h0) $display("FAIL halt_reset_pc got %h want 0", pc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL halt_reset_flag got %b want 0", halted); else n_pass++;
    endtask

    task automatic test_reset_mid_redirect();
        do_reset();
        goto_pc(32'h60);
        jump_en = 1; jump_target = 32'h700;
        #2;
        rst = 1;
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL midrst_pc got %h want 0", pc); else n_pass++;
        clear_inputs();
        @(negedge clk);
        rst = 0;
        tick();
        n_checks++; if (pc_valid !== 1'b1) $display("FAIL midrst_valid got %b want 1", pc_valid); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL midrst_first_pc got %h want 0", pc); else n_pass++;
    endtask

    task automatic test_link();
        logic [31:0] exp_link;
`ifdef NEXT_PC_LINK_EN
        exp_link = 32'h34;
`else
        exp_link = 32'h0;
`endif
        do_reset();
        goto_pc(32'h30);
        jump_en = 1; link_en = 1; jump_target = 32'h400;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h400) $display("FAIL link_jump_pc got %h want 400", pc); else n_pass++;
        n_checks++; if (link_addr !== exp_link) $display("FAIL link_addr got %h want %h", link_addr, exp_link); else n_pass++;
        jump_en = 1; jump_target = 32'h10;
        tick();
        clear_inputs();
        n_checks++; if (link_addr !== exp_link) $display("FAIL link_hold got %h want %h", link_addr, exp_link); else n_pass++;
        stall = 1; jump_en = 1; link_en = 1; jump_target = 32'h800;
        tick();
        clear_inputs();
        n_checks++; if (link_addr !== exp_link) $display("FAIL link_stall_hold got %h want %h", link_addr, exp_link); else n_pass++;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch_wrap();
        test_priority();
        test_misaligned();
        test_halt();
        test_reset_mid_redirect();
        test_link();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
